// File: rtl/idli_alu_m.sv
// -----------------------------------------------------------------------------
// idli_alu_m : nibble-serial 16-bit ALU.
//
// One operation takes four beats, least-significant nibble first. Beat 0 is the
// cycle in which i_alu_start is accepted. The result nibble is produced
// combinationally from the current B/C nibbles, so the GRF captures it on the
// same edge. Carry ripples between beats through carry_q. The Z/C/N flags are
// updated on the beat-3 edge and hold until the next completion.
//
// Ports:
//   i_alu_gck     gated core clock
//   i_alu_rst     asynchronous active-high reset
//   i_alu_start   start pulse, accepted only while idle (that cycle is beat 0)
//   i_alu_op      operation, sampled on an accepted start
//   i_alu_dst     destination GREG, sampled on an accepted start
//   i_alu_b_data  B operand nibble (GRF B read port)
//   i_alu_c_data  C operand nibble (GRF C read port)
//   o_alu_busy    high during beats 1..3
//   o_alu_a       destination register to GRF write port A
//   o_alu_a_vld   write enable to GRF write port A
//   o_alu_a_data  result nibble to GRF write port A
//   o_alu_done    one-cycle pulse in the cycle after beat 3
//   o_alu_flag_z  zero flag
//   o_alu_flag_c  carry / not-borrow flag
//   o_alu_flag_n  negative flag (result bit 15)
// -----------------------------------------------------------------------------
module idli_alu_m (
    input  logic       i_alu_gck,
    input  logic       i_alu_rst,
    input  logic       i_alu_start,
    input  logic [2:0] i_alu_op,
    input  logic [2:0] i_alu_dst,
    input  logic [3:0] i_alu_b_data,
    input  logic [3:0] i_alu_c_data,
    output logic       o_alu_busy,
    output logic [2:0] o_alu_a,
    output logic       o_alu_a_vld,
    output logic [3:0] o_alu_a_data,
    output logic       o_alu_done,
    output logic       o_alu_flag_z,
    output logic       o_alu_flag_c,
    output logic       o_alu_flag_n
);

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_ANDN = 3'd5,
        OP_MOVB = 3'd6,
        OP_CMP  = 3'd7
    } alu_op_e;

    logic       busy_q,  busy_d;
    logic [1:0] beat_q,  beat_d;
    logic [2:0] op_q,    op_d;
    logic [2:0] dst_q,   dst_d;
    logic       carry_q, carry_d;
    logic       zacc_q,  zacc_d;
    logic       flag_z_q, flag_z_d;
    logic       flag_c_q, flag_c_d;
    logic       flag_n_q, flag_n_d;
    logic       done_q,  done_d;

    logic       active;
    logic [1:0] beat;
    alu_op_e    op_eff;
    logic [2:0] dst_eff;
    logic       cin;
    logic [4:0] sum;
    logic [3:0] res;
    logic       cout;
    logic       res_nz;

    // NOTE: every signal assigned in this always_comb gets a default first so
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        // Reset gates the combinational write port so nothing is written to
        // the GRF while reset is asserted, even if a start is presented.
        active  = ~i_alu_rst & (i_alu_start | busy_q);
        beat    = busy_q ? beat_q : 2'd0;
        op_eff  = alu_op_e'(busy_q ? op_q : i_alu_op);
        dst_eff = busy_q ? dst_q : i_alu_dst;

        // Subtraction is b + ~c + 1: the +1 enters as the beat-0 carry-in.
        if (beat == 2'd0) begin
            cin = (op_eff == OP_SUB) || (op_eff == OP_CMP);
        end else begin
            cin = carry_q;
        end

        sum  = 5'd0;
        res  = 4'd0;
        cout = 1'b0;
        unique case (op_eff)
            OP_ADD: begin
                sum  = {1'b0, i_alu_b_data} + {1'b0, i_alu_c_data} + {4'd0, cin};
                res  = sum[3:0];
                cout = sum[4];
            end
            OP_SUB, OP_CMP: begin
                sum  = {1'b0, i_alu_b_data} + {1'b0, ~i_alu_c_data} + {4'd0, cin};
                res  = sum[3:0];
                cout = sum[4];
            end
            OP_AND:  res = i_alu_b_data & i_alu_c_data;
            OP_OR:   res = i_alu_b_data | i_alu_c_data;
            OP_XOR:  res = i_alu_b_data ^ i_alu_c_data;
            OP_ANDN: res = i_alu_b_data & ~i_alu_c_data;
            OP_MOVB: res = i_alu_b_data;
            default: res = 4'd0;
        endcase
        res_nz = (res != 4'd0);

        o_alu_a_data = active ? res : 4'd0;
        o_alu_a_vld  = active & (op_eff != OP_CMP);
        o_alu_a      = active ? dst_eff : 3'd0;
        o_alu_busy   = busy_q;
        o_alu_done   = done_q;
        o_alu_flag_z = flag_z_q;
        o_alu_flag_c = flag_c_q;
        o_alu_flag_n = flag_n_q;

        busy_d   = busy_q;
        beat_d   = beat_q;
        op_d     = op_q;
        dst_d    = dst_q;
        carry_d  = carry_q;
        zacc_d   = zacc_q;
        flag_z_d = flag_z_q;
        flag_c_d = flag_c_q;
        flag_n_d = flag_n_q;
        done_d   = 1'b0;

        if (active) begin
            carry_d = cout;
            if (!busy_q) begin
                // Beat 0: capture the operation; a start while busy never
                // reaches this branch and so has no effect.
                op_d   = i_alu_op;
                dst_d  = i_alu_dst;
                busy_d = 1'b1;
                beat_d = 2'd1;
                zacc_d = res_nz;
            end else if (beat_q == 2'd3) begin
                busy_d   = 1'b0;
                beat_d   = 2'd0;
                done_d   = 1'b1;
                flag_z_d = ~(zacc_q | res_nz);
                flag_c_d = cout;
                flag_n_d = res[3];
            end else begin
                beat_d = beat_q + 2'd1;
                zacc_d = zacc_q | res_nz;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_alu_gck or posedge i_alu_rst) begin
        if (i_alu_rst) begin
            busy_q   <= 1'b0;
            beat_q   <= 2'd0;
            op_q     <= 3'd0;
            dst_q    <= 3'd0;
            carry_q  <= 1'b0;
            zacc_q   <= 1'b0;
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
            flag_n_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            beat_q   <= beat_d;
            op_q     <= op_d;
            dst_q    <= dst_d;
            carry_q  <= carry_d;
            zacc_q   <= zacc_d;
            flag_z_q <= flag_z_d;
            flag_c_q <= flag_c_d;
            flag_n_q <= flag_n_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_idli_alu_m.sv
// -----------------------------------------------------------------------------
// tb_idli_alu_m : directed self-checking bench for idli_alu_m.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_idli_alu_m;

    logic       clk;
    logic       rst;
    logic       start;
    logic [2:0] op;
    logic [2:0] dst;
    logic [3:0] b_data;
    logic [3:0] c_data;
    logic       busy;
    logic [2:0] a;
    logic       a_vld;
    logic [3:0] a_data;
    logic       done;
    logic       flag_z;
    logic       flag_c;
    logic       flag_n;

    int total = 0;
    int bad   = 0;

    // Expected flags of the most recently issued operation.
    logic g_z, g_c, g_n;

    idli_alu_m dut (
        .i_alu_gck    (clk),
        .i_alu_rst    (rst),
        .i_alu_start  (start),
        .i_alu_op     (op),
        .i_alu_dst    (dst),
        .i_alu_b_data (b_data),
        .i_alu_c_data (c_data),
        .o_alu_busy   (busy),
        .o_alu_a      (a),
        .o_alu_a_vld  (a_vld),
        .o_alu_a_data (a_data),
        .o_alu_done   (done),
        .o_alu_flag_z (flag_z),
        .o_alu_flag_c (flag_c),
        .o_alu_flag_n (flag_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_flags(input string tag, input logic z, input logic c, input logic n);
        check({tag, "_z"}, 16'(flag_z), 16'(z));
        check({tag, "_c"}, 16'(flag_c), 16'(c));
        check({tag, "_n"}, 16'(flag_n), 16'(n));
    endtask

    // Runs the four beats of one operation. After beat 0 the op/dst inputs are
    // driven to their complement so that a change in op_q/dst_q would show.
    // b2b: beat 0 falls in the done cycle of the previous operation.
    // poke: beat index at which a (to-be-ignored) start is pulsed, or -1.
    task automatic do_op(input logic [2:0] o, input logic [2:0] d,
                         input logic [15:0] bv, input logic [15:0] cv,
                         input logic [15:0] ev, input logic vld,
                         input logic ez, input logic ec, input logic en,
                         input bit b2b, input int poke);
        logic pz, pc, pn;
        pz = g_z; pc = g_c; pn = g_n;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            start  = (k == 0) || (k == poke);
            op     = (k == 0) ? o : ~o;
            dst    = (k == 0) ? d : ~d;
            b_data = bv[4*k +: 4];
            c_data = cv[4*k +: 4];
            #1;
            check($sformatf("a_data_b%0d", k), 16'(a_data), 16'(ev[4*k +: 4]));
            check($sformatf("a_vld_b%0d", k), 16'(a_vld), 16'(vld));
            check($sformatf("a_b%0d", k), 16'(a), 16'(d));
            check($sformatf("busy_b%0d", k), 16'(busy), 16'(k != 0));
            check($sformatf("done_b%0d", k), 16'(done), 16'((k == 0) && b2b));
            if (k == 0 && b2b) check_flags("prev", pz, pc, pn);
        end
        g_z = ez; g_c = ec; g_n = en;
    endtask

    // Idle cycle after beat 3: done pulse with the new flags, then done clears.
    task automatic finish_op();
        @(negedge clk);
        start = 1'b0; b_data = 4'd0; c_data = 4'd0;
        #1;
        check("done", 16'(done), 16'd1);
        check("idle_busy", 16'(busy), 16'd0);
        check("idle_vld", 16'(a_vld), 16'd0);
        check("idle_a", 16'(a), 16'd0);
        check("idle_data", 16'(a_data), 16'd0);
        check_flags("fl", g_z, g_c, g_n);
        @(negedge clk);
        #1;
        check("done_clr", 16'(done), 16'd0);
        check_flags("fl_hold", g_z, g_c, g_n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; op = 3'd0; dst = 3'd0;
        b_data = 4'd0; c_data = 4'd0;
        g_z = 1'b0; g_c = 1'b0; g_n = 1'b0;
        #1;
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_vld", 16'(a_vld), 16'd0);
        check("rst_a", 16'(a), 16'd0);
        check("rst_data", 16'(a_data), 16'd0);
        check("rst_done", 16'(done), 16'd0);
        check_flags("rst", 1'b0, 1'b0, 1'b0);
        // Start presented during reset must not open the write port.
        start = 1'b1; op = 3'd0; dst = 3'd5; b_data = 4'd3;
        #1;
        check("rst_start_vld", 16'(a_vld), 16'd0);
        check("rst_start_data", 16'(a_data), 16'd0);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 1. ADD 0x1234 + 0x0FFF = 0x2233
        do_op(3'd0, 3'd3, 16'h1234, 16'h0FFF, 16'h2233, 1'b1, 1'b0, 1'b0, 1'b0, 0, -1);
        finish_op();
        // 2. ADD 0xFFFF + 0x0001 = 0x0000 carry out
        do_op(3'd0, 3'd1, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 0, -1);
        finish_op();
        // 3. SUB 5-5 = 0 (no borrow); CMP 3 vs 5 -> 0xFFFE, borrow, no write
        do_op(3'd1, 3'd2, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 0, -1);
        finish_op();
        do_op(3'd7, 3'd4, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1, 0, -1);
        finish_op();
        // 4. XOR with ignored start in beat 2, then AND back-to-back
        do_op(3'd4, 3'd6, 16'h1234, 16'h00FF, 16'h12CB, 1'b1, 1'b0, 1'b0, 1'b0, 0, 2);
        do_op(3'd2, 3'd5, 16'hF0F0, 16'hFF00, 16'hF000, 1'b1, 1'b0, 1'b0, 1'b1, 1, -1);
        finish_op();

        // 5. Async reset in beat 2 of ADD 0x1111 + 0x2222 (flags are z0 c0 n1 now)
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            start  = (k == 0);
            op     = 3'd0;
            dst    = 3'd2;
            b_data = 4'd1;
            c_data = 4'd2;
        end
        #1;
        check("pre_rst_vld", 16'(a_vld), 16'd1);
        check("pre_rst_data", 16'(a_data), 16'd3);
        rst = 1'b1;
        #1;
        check("mid_rst_vld", 16'(a_vld), 16'd0);
        check("mid_rst_busy", 16'(busy), 16'd0);
        check("mid_rst_data", 16'(a_data), 16'd0);
        check("mid_rst_a", 16'(a), 16'd0);
        check_flags("mid_rst", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0; b_data = 4'd0; c_data = 4'd0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check("post_rst_done", 16'(done), 16'd0);
        end
        g_z = 1'b0; g_c = 1'b0; g_n = 1'b0;
        do_op(3'd0, 3'd1, 16'h0001, 16'h0001, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0, 0, -1);
        finish_op();

        // 6. MOVB and ANDN with b=0x8001, c=0x0001
        do_op(3'd6, 3'd7, 16'h8001, 16'h0001, 16'h8001, 1'b1, 1'b0, 1'b0, 1'b1, 0, -1);
        finish_op();
        do_op(3'd5, 3'd3, 16'h8001, 16'h0001, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b1, 0, -1);
        finish_op();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
